// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg
// Shared defines for the MEM stage: bus widths, operation and category
// encodings, stall codes and the MEM-stage state encoding. Also provides
// small helpers that decode access size and load signedness from the op.
package mem_access_stage_pkg;

    // Bus widths used across the core
    typedef logic [4:0]  reg_addr_bus_t;
    typedef logic [31:0] reg_bus_t;
    typedef logic [31:0] mem_addr_bus_t;
    typedef logic [7:0]  mem_data_bus_t;
    typedef logic [7:0]  op_bus_t;
    typedef logic [2:0]  catagory_bus_t;

    // Operation encodings meaningful to the MEM stage
    localparam op_bus_t OP_LB  = 8'h01;
    localparam op_bus_t OP_LH  = 8'h02;
    localparam op_bus_t OP_LW  = 8'h03;
    localparam op_bus_t OP_LBU = 8'h04;
    localparam op_bus_t OP_LHU = 8'h05;
    localparam op_bus_t OP_SB  = 8'h06;
    localparam op_bus_t OP_SH  = 8'h07;
    localparam op_bus_t OP_SW  = 8'h08;

    // Category codes; every other value (including zero) means "other"
    localparam catagory_bus_t CAT_LOAD  = 3'd1;
    localparam catagory_bus_t CAT_STORE = 3'd2;

    // Stall controller request codes
    typedef enum logic [1:0] {
        STALL_PASS = 2'd0,
        STALL_HOLD = 2'd1,
        STALL_BUBB = 2'd2
    } stall_t;

    // MEM-stage sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2
    } state_t;

    // Number of bytes moved by a memory op: 1, 2 or 4
    function automatic logic [2:0] access_size(input op_bus_t op);
        case (op)
            OP_LW, OP_SW:          return 3'd4;
            OP_LH, OP_LHU, OP_SH:  return 3'd2;
            default:               return 3'd1;
        endcase
    endfunction

    // Only LB and LH sign-extend
    function automatic logic is_signed_load(input op_bus_t op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// load_extend
// Combinational sign/zero extension of a little-endian load result.
// Ports:
//   raw      in  32  assembled bytes, byte 0 in bits [7:0]
//   size     in  3   access size in bytes (1, 2 or 4)
//   sign_ext in  1   1 = sign-extend, 0 = zero-extend
//   result   out 32  extended load value
module load_extend
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    always_comb begin
        result = raw;
        case (size)
            3'd1:    result = {{24{sign_ext & raw[7]}}, raw[7:0]};
            3'd2:    result = {{16{sign_ext & raw[15]}}, raw[15:0]};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
// MEM stage of the five-stage core. Sequences loads and stores over a
// byte-wide synchronous data RAM one byte per cycle, requesting a pipeline
// hold until the access finishes. Non-memory ops pass straight through.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rd_addr_i/rd_write_i/rd_data_i  destination info from EX/MEM
//   mem_addr_i, mem_data_i        effective byte address, store data
//   op_i, catagory_i              operation and category
//   ram_addr/ram_we/ram_wdata     data RAM request (one byte per cycle)
//   ram_rdata                     RAM read byte, valid one cycle after address
//   stall_req                     hold request to the stall controller
//   rd_addr_o/rd_write_o/rd_data_o  write-back result to MEM/WB and forwarding
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rd_addr_i,
    input  logic        rd_write_i,
    input  logic [31:0] rd_data_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic [7:0]  op_i,
    input  logic [2:0]  catagory_i,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        stall_req,
    output logic [4:0]  rd_addr_o,
    output logic        rd_write_o,
    output logic [31:0] rd_data_o
);

    state_t      state, state_next;
    logic [1:0]  cnt, cnt_next;
    logic [23:0] buffer, buffer_next;
    logic [2:0]  size;
    logic [1:0]  last_store_cnt;
    logic [31:0] raw_word;
    logic [31:0] load_result;

    assign size           = access_size(op_i);
    assign last_store_cnt = size[1:0] - 2'd1;

    // State, byte counter and load buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= 2'd0;
            buffer <= 24'd0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            buffer <= buffer_next;
        end
    end

    // Assemble the raw little-endian word: earlier bytes come from the
    // buffer, the last byte is the one arriving on ram_rdata right now.
    always_comb begin
        raw_word = 32'd0;
        case (size)
            3'd1:    raw_word = {24'd0, ram_rdata};
            3'd2:    raw_word = {16'd0, ram_rdata, buffer[7:0]};
            default: raw_word = {ram_rdata, buffer};
        endcase
    end

    load_extend u_load_extend (
        .raw      (raw_word),
        .size     (size),
        .sign_ext (is_signed_load(op_i)),
        .result   (load_result)
    );

    // Next-state and output logic. A word load runs the 2-bit counter
    // 1,2,3 and then wraps to 0, so the "last byte" test compares against
    // size[1:0], where a size of 4 reads as 0.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        buffer_next = buffer;
        ram_addr    = 32'd0;
        ram_we      = 1'b0;
        ram_wdata   = 8'd0;
        stall_req   = 1'b0;
        rd_addr_o   = rd_addr_i;
        rd_write_o  = 1'b0;
        rd_data_o   = rd_data_i;

        case (state)
            ST_IDLE: begin
                if (catagory_i == CAT_LOAD) begin
                    ram_addr   = mem_addr_i;
                    cnt_next   = 2'd1;
                    state_next = ST_LOAD;
                    stall_req  = 1'b1;
                end else if (catagory_i == CAT_STORE) begin
                    ram_we    = 1'b1;
                    ram_addr  = mem_addr_i;
                    ram_wdata = mem_data_i[7:0];
                    if (size != 3'd1) begin
                        cnt_next   = 2'd1;
                        state_next = ST_STORE;
                        stall_req  = 1'b1;
                    end
                end else begin
                    rd_write_o = rd_write_i;
                end
            end

            ST_LOAD: begin
                case (cnt)
                    2'd1:    buffer_next[7:0]   = ram_rdata;
                    2'd2:    buffer_next[15:8]  = ram_rdata;
                    2'd3:    buffer_next[23:16] = ram_rdata;
                    default: buffer_next        = buffer;
                endcase
                if (cnt == size[1:0]) begin
                    rd_write_o = rd_write_i;
                    rd_data_o  = load_result;
                    cnt_next   = 2'd0;
                    state_next = ST_IDLE;
                end else begin
                    ram_addr  = mem_addr_i + {30'd0, cnt};
                    cnt_next  = cnt + 2'd1;
                    stall_req = 1'b1;
                end
            end

            ST_STORE: begin
                ram_we   = 1'b1;
                ram_addr = mem_addr_i + {30'd0, cnt};
                case (cnt)
                    2'd1:    ram_wdata = mem_data_i[15:8];
                    2'd2:    ram_wdata = mem_data_i[23:16];
                    2'd3:    ram_wdata = mem_data_i[31:24];
                    default: ram_wdata = mem_data_i[7:0];
                endcase
                if (cnt == last_store_cnt) begin
                    cnt_next   = 2'd0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next  = cnt + 2'd1;
                    stall_req = 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = 2'd0;
            end
        endcase

        // Reset silences every output so nothing leaks into RAM or write-back
        if (rst) begin
            ram_addr   = 32'd0;
            ram_we     = 1'b0;
            ram_wdata  = 8'd0;
            stall_req  = 1'b0;
            rd_addr_o  = 5'd0;
            rd_write_o = 1'b0;
            rd_data_o  = 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
// Self-checking bench for mem_access_stage: directed cases followed by
// randomized loads/stores/ALU ops, each checked cycle by cycle against an
// instruction-level reference model with its own byte memory.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr_i;
    logic        rd_write_i;
    logic [31:0] rd_data_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [7:0]  op_i;
    logic [2:0]  catagory_i;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'd0;
    logic        stall_req;
    logic [4:0]  rd_addr_o;
    logic        rd_write_o;
    logic [31:0] rd_data_o;

    logic [7:0] dev_ram [logic [31:0]];
    logic [7:0] ref_ram [logic [31:0]];

    int total = 0;
    int bad   = 0;

    localparam logic [7:0] OP_ADD = 8'h20;

    mem_access_stage dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr_i  (rd_addr_i),
        .rd_write_i (rd_write_i),
        .rd_data_i  (rd_data_i),
        .mem_addr_i (mem_addr_i),
        .mem_data_i (mem_data_i),
        .op_i       (op_i),
        .catagory_i (catagory_i),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .stall_req  (stall_req),
        .rd_addr_o  (rd_addr_o),
        .rd_write_o (rd_write_o),
        .rd_data_o  (rd_data_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] devRead(input logic [31:0] a);
        return dev_ram.exists(a) ? dev_ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] refRead(input logic [31:0] a);
        return ref_ram.exists(a) ? ref_ram[a] : 8'h00;
    endfunction

    // Synchronous byte RAM seen by the DUT: read data one cycle later
    always @(posedge clk) begin
        if (ram_we) dev_ram[ram_addr] = ram_wdata;
        ram_rdata <= devRead(ram_addr);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] cat, input logic [7:0] op,
                                 input logic [4:0] rda, input logic rdw,
                                 input logic [31:0] rdd, input logic [31:0] addr,
                                 input logic [31:0] data);
        catagory_i = cat;
        op_i       = op;
        rd_addr_i  = rda;
        rd_write_i = rdw;
        rd_data_i  = rdd;
        mem_addr_i = addr;
        mem_data_i = data;
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        dev_ram[a] = b;
        ref_ram[a] = b;
    endtask

    // Runs one instruction from its first cycle; returns just after the
    // edge that ends its last cycle, ready for the next one.
    task automatic runInstr(input logic [2:0] cat, input logic [7:0] op,
                            input logic [4:0] rda, input logic rdw,
                            input logic [31:0] rdd, input logic [31:0] addr,
                            input logic [31:0] data);
        int n, cycles;
        bit is_load, is_store, sgn;
        longint v;
        logic [31:0] exp_val, a;
        logic [7:0]  b;
        logic [31:0] dshift;

        n        = (op == OP_LW || op == OP_SW) ? 4 :
                   (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 1;
        is_load  = (cat == CAT_LOAD);
        is_store = (cat == CAT_STORE);
        sgn      = (op == OP_LB || op == OP_LH);
        cycles   = is_load ? n + 1 : (is_store ? n : 1);

        v = 0;
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            v = v + (longint'(refRead(a)) << (8 * k));
        end
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v + (longint'(1) << 32) - (longint'(1) << (8 * n));
        exp_val = v[31:0];

        applyStimulus(cat, op, rda, rdw, rdd, addr, data);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            a = addr + 32'(c);
            checkOutput("stall_req", {31'd0, stall_req}, {31'd0, (c < cycles - 1)});
            checkOutput("ram_we", {31'd0, ram_we}, {31'd0, is_store});
            if (is_store) begin
                dshift = data >> (8 * c);
                checkOutput("store_addr", ram_addr, a);
                checkOutput("store_byte", {24'd0, ram_wdata}, {24'd0, dshift[7:0]});
            end
            if (is_load && c < n)
                checkOutput("load_addr", ram_addr, a);
            if (c == cycles - 1) begin
                checkOutput("rd_write_o", {31'd0, rd_write_o}, {31'd0, (!is_store && rdw)});
                if (!is_store && rdw) begin
                    checkOutput("rd_addr_o", {27'd0, rd_addr_o}, {27'd0, rda});
                    checkOutput("rd_data_o", rd_data_o, is_load ? exp_val : rdd);
                end
            end else begin
                checkOutput("rd_write_hold", {31'd0, rd_write_o}, 32'd0);
            end
            @(posedge clk);
            #1;
        end

        if (is_store) begin
            for (int k = 0; k < n; k++) begin
                dshift = data >> (8 * k);
                b = dshift[7:0];
                ref_ram[addr + 32'(k)] = b;
            end
        end
    endtask

    logic [7:0] load_ops  [5] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    logic [7:0] store_ops [3] = '{OP_SB, OP_SH, OP_SW};

    initial begin
        logic [31:0] raddr;
        int kind;

        // Reset with a live load on the inputs: everything must stay quiet
        rst = 1'b1;
        applyStimulus(CAT_LOAD, OP_LW, 5'd7, 1'b1, 32'hDEADBEEF, 32'h100, 32'h11223344);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_stall", {31'd0, stall_req}, 32'd0);
        checkOutput("rst_we", {31'd0, ram_we}, 32'd0);
        checkOutput("rst_addr", ram_addr, 32'd0);
        checkOutput("rst_wdata", {24'd0, ram_wdata}, 32'd0);
        checkOutput("rst_rd_write", {31'd0, rd_write_o}, 32'd0);
        checkOutput("rst_rd_addr", {27'd0, rd_addr_o}, 32'd0);
        checkOutput("rst_rd_data", rd_data_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        preload(32'h100, 8'h78);
        preload(32'h101, 8'h56);
        preload(32'h102, 8'h34);
        preload(32'h103, 8'h12);
        preload(32'h200, 8'h80);

        // Directed cases
        runInstr(CAT_LOAD, OP_LW, 5'd1, 1'b1, 32'h0, 32'h100, 32'h0);
        runInstr(CAT_LOAD, OP_LB, 5'd2, 1'b1, 32'h0, 32'h200, 32'h0);
        runInstr(CAT_LOAD, OP_LBU, 5'd2, 1'b1, 32'h0, 32'h200, 32'h0);
        runInstr(CAT_STORE, OP_SH, 5'd0, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h0000BEEF);
        runInstr(CAT_LOAD, OP_LHU, 5'd4, 1'b1, 32'h0, 32'hFFFFFFFF, 32'h0);
        runInstr(CAT_LOAD, OP_LH, 5'd4, 1'b1, 32'h0, 32'hFFFFFFFF, 32'h0);
        runInstr(CAT_STORE, OP_SW, 5'd0, 1'b0, 32'h0, 32'h300, 32'hCAFEF00D);
        runInstr(CAT_LOAD, OP_LW, 5'd5, 1'b1, 32'h0, 32'h300, 32'h0);
        runInstr(3'd0, OP_ADD, 5'd3, 1'b1, 32'h5, 32'h0, 32'h0);
        runInstr(3'd0, 8'h00, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
        runInstr(CAT_STORE, OP_SB, 5'd0, 1'b0, 32'h0, 32'h201, 32'h000000A5);
        runInstr(CAT_LOAD, OP_LH, 5'd6, 1'b1, 32'h0, 32'h200, 32'h0);

        // Reset landing on the third cycle of a word load
        applyStimulus(CAT_LOAD, OP_LW, 5'd9, 1'b1, 32'h0, 32'h100, 32'h0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("pre_rst_stall", {31'd0, stall_req}, 32'd1);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_stall", {31'd0, stall_req}, 32'd0);
        checkOutput("mid_rst_rd_write", {31'd0, rd_write_o}, 32'd0);
        checkOutput("mid_rst_addr", ram_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(3'd0, 8'h00, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("post_rst_stall", {31'd0, stall_req}, 32'd0);
        checkOutput("post_rst_rd_write", {31'd0, rd_write_o}, 32'd0);
        @(posedge clk);
        #1;
        runInstr(CAT_LOAD, OP_LB, 5'd10, 1'b1, 32'h0, 32'h200, 32'h0);

        // Randomized traffic around a small window and the address wrap point
        for (int i = 0; i < 120; i++) begin
            raddr = ($urandom_range(0, 2) != 0) ? 32'h400 + $urandom_range(0, 31)
                                                : 32'hFFFFFFF0 + $urandom_range(0, 15);
            kind = $urandom_range(0, 2);
            if (kind == 0)
                runInstr(CAT_LOAD, load_ops[$urandom_range(0, 4)], 5'($urandom_range(1, 31)),
                         1'b1, $urandom, raddr, $urandom);
            else if (kind == 1)
                runInstr(CAT_STORE, store_ops[$urandom_range(0, 2)], 5'($urandom_range(0, 31)),
                         1'b0, $urandom, raddr, $urandom);
            else
                runInstr(3'($urandom_range(3, 7)), OP_ADD, 5'($urandom_range(0, 31)),
                         1'($urandom_range(0, 1)), $urandom, raddr, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
